// File: rtl/chsel_pfb_pkg.sv
// Shared types and constants for the PFB channel-selector puncture scheduler.
package chsel_pfb_pkg;

  localparam int PUNCT_W  = 32;
  localparam int SCHED_DW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    STOP = 2'd3
  } sched_st_t;

  typedef struct packed {
    logic [PUNCT_W-1:0]  mask;
    logic [SCHED_DW-1:0] dwell;
  } sched_ent_t;

  // Dwell counter reload value: an entry is held for max(dwell,1) frames,
  // and the counter counts the frames remaining after the current one.
  function automatic logic [SCHED_DW-1:0] dwell_load(input logic [SCHED_DW-1:0] d);
    return (d == '0) ? '0 : d - SCHED_DW'(1);
  endfunction

endpackage

// File: rtl/chsel_pfb_sched_tbl.sv
// Schedule table: NE entries of {mask, dwell}, one write port, one
// combinational read port. A write lands on the clock edge, so a load taken
// on the same edge as a write to that index sees the old contents.
module chsel_pfb_sched_tbl
  import chsel_pfb_pkg::*;
#(
  parameter int NE = 16,
  localparam int AW = $clog2(NE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  sched_ent_t    wdata,
  input  logic [AW-1:0] raddr,
  output sched_ent_t    rdata
);

  sched_ent_t mem_q [NE];
  sched_ent_t mem_d [NE];

  // Next table contents: copy, then overlay the single write.
  always_comb begin
    for (int i = 0; i < NE; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  // Table storage, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NE; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NE; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/chsel_pfb_sched.sv
// Frame-synchronous scheduler for the PFB channel-selector puncturing block.
// Walks the schedule table and updates START/PUNCT only on frame-boundary
// beats, so the puncture mask never changes inside a TDM frame.
//
// The AXI-stream side is monitor-only: a beat is any cycle with
// s_axis_tvalid=1 (there is no ready; the datapath owns backpressure), and a
// frame boundary is a beat with s_axis_tlast=1.
module chsel_pfb_sched
  import chsel_pfb_pkg::*;
#(
  parameter int NT = 8,
  parameter int NE = 16,
  parameter int DW = SCHED_DW,
  localparam int AW = $clog2(NE),
  localparam int LW = AW + 1,
  localparam int BW = $clog2(NT + 1)
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               cfg_we,
  input  logic [AW-1:0]      cfg_addr,
  input  logic [PUNCT_W-1:0] cfg_mask,
  input  logic [DW-1:0]      cfg_dwell,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_loop,
  input  logic               cfg_start,
  input  logic               s_axis_tvalid,
  input  logic               s_axis_tlast,
  output logic               start_o,
  output logic [PUNCT_W-1:0] punct_o,
  output logic [AW-1:0]      entry_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               frm_err_o
);

  sched_st_t          state_q, state_d;
  logic               start_q, start_d;
  logic [PUNCT_W-1:0] punct_q, punct_d;
  logic [AW-1:0]      entry_q, entry_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [LW-1:0]      len_q, len_d;
  logic [DW-1:0]      dwell_q, dwell_d;
  logic [BW-1:0]      beat_q, beat_d;

  logic               fb;
  logic               last_idx;
  logic [AW-1:0]      nxt_idx;
  logic [AW-1:0]      rd_addr;
  sched_ent_t         rd_ent;
  sched_ent_t         wr_ent;
  logic [DW-1:0]      dwell_ld;

  assign fb       = s_axis_tvalid & s_axis_tlast;
  assign last_idx = ({1'b0, entry_q} == (len_q - LW'(1)));
  assign nxt_idx  = last_idx ? '0 : entry_q + AW'(1);
  // ARM always loads entry 0; RUN loads the entry that follows the current one.
  assign rd_addr  = (state_q == ARM) ? '0 : nxt_idx;
  assign dwell_ld = DW'(dwell_load(rd_ent.dwell));

  assign wr_ent.mask  = cfg_mask;
  assign wr_ent.dwell = SCHED_DW'(cfg_dwell);

  chsel_pfb_sched_tbl #(
    .NE (NE)
  ) u_tbl (
    .clk   (aclk),
    .rst_n (aresetn),
    .we    (cfg_we),
    .waddr (cfg_addr),
    .wdata (wr_ent),
    .raddr (rd_addr),
    .rdata (rd_ent)
  );

  // Next-state logic: beat counter, frame-length check and schedule FSM.
  always_comb begin
    state_d = state_q;
    start_d = start_q;
    punct_d = punct_q;
    entry_d = entry_q;
    done_d  = 1'b0;
    err_d   = err_q;
    len_d   = len_q;
    dwell_d = dwell_q;
    beat_d  = beat_q;

    // Counter saturates at NT, which is already enough to flag a long frame.
    if (fb) begin
      beat_d = '0;
    end else if (s_axis_tvalid && (beat_q != BW'(NT))) begin
      beat_d = beat_q + BW'(1);
    end
    if (fb && (beat_q != BW'(NT - 1))) begin
      err_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (cfg_start && (cfg_len != '0)) begin
          state_d = ARM;
          len_d   = cfg_len;
          err_d   = 1'b0;
        end
      end
      ARM: begin
        if (!cfg_start) begin
          state_d = IDLE;
        end else if (fb) begin
          state_d = RUN;
          start_d = 1'b1;
          punct_d = rd_ent.mask;
          entry_d = '0;
          dwell_d = dwell_ld;
        end
      end
      RUN: begin
        if (fb) begin
          if (!cfg_start) begin
            state_d = STOP;
            start_d = 1'b0;
            done_d  = 1'b1;
          end else if (dwell_q != '0) begin
            dwell_d = dwell_q - DW'(1);
          end else if (last_idx && !cfg_loop) begin
            state_d = STOP;
            start_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            entry_d = nxt_idx;
            punct_d = rd_ent.mask;
            dwell_d = dwell_ld;
          end
        end
      end
      STOP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All scheduler state and registered outputs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      punct_q <= '0;
      entry_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      len_q   <= '0;
      dwell_q <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      punct_q <= punct_d;
      entry_q <= entry_d;
      done_q  <= done_d;
      err_q   <= err_d;
      len_q   <= len_d;
      dwell_q <= dwell_d;
      beat_q  <= beat_d;
    end
  end

  assign start_o   = start_q;
  assign punct_o   = punct_q;
  assign entry_o   = entry_q;
  assign busy_o    = (state_q != IDLE);
  assign done_o    = done_q;
  assign frm_err_o = err_q;

endmodule
